game_ctrl: RTL

Game-flow controller that sequences the BCD score counter block (four digits: thous/huns/tens/ones). It edge-detects start, obstacle-pass and collision inputs and runs the IDLE/PLAY/HIT/OVER state machine. It issues one-cycle score_clr/score_inc commands to the score datapath, tracks remaining lives, and latches a high score from the returned digits at game over.

---
 rtl/game_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/game_ctrl.sv
// Game-flow controller: edge-detects start/pass/collision, runs the IDLE/PLAY/HIT/OVER flow,
// commands the BCD score block and keeps lives and a persistent high score.
module game_ctrl #(
   parameter int unsigned LIVES    = 3,
   parameter int unsigned HIT_HOLD = 50
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        pass_evt,
   input  logic        collision,
   input  logic [3:0]  thous,
   input  logic [3:0]  huns,
   input  logic [3:0]  tens,
   input  logic [3:0]  ones,
   output logic        score_clr,
   output logic        score_inc,
   output logic [2:0]  lives,
   output logic        playing,
   output logic        hit_active,
   output logic        game_over,
   output logic        new_high,
   output logic [15:0] hi_score
);

   typedef enum logic [1:0] {StIdle, StPlay, StHit, StOver} state_e;

   localparam logic [2:0]  LivesInit = 3'(LIVES);
   localparam logic [15:0] HoldInit  = 16'(HIT_HOLD);

   state_e      state_q, state_d;
   logic [2:0]  lives_q, lives_d;
   logic [15:0] hi_q, hi_d;
   logic [15:0] hold_q, hold_d;
   logic        clr_q, clr_d;
   logic        inc_q, inc_d;
   logic        new_high_q, new_high_d;
   logic        over_first_q, over_first_d;
   logic        start_prev_q, pass_prev_q, coll_prev_q;

   logic        start_ev, pass_ev, coll_ev;
   logic [15:0] score;
   logic        saturated;

   assign start_ev  = start & ~start_prev_q;
   assign pass_ev   = pass_evt & ~pass_prev_q;
   assign coll_ev   = collision & ~coll_prev_q;
   assign score     = {thous, huns, tens, ones};
   assign saturated = (score == 16'h9999);

   always_comb begin
      state_d      = state_q;
      lives_d      = lives_q;
      hi_d         = hi_q;
      hold_d       = hold_q;
      clr_d        = 1'b0;
      inc_d        = 1'b0;
      new_high_d   = new_high_q;
      over_first_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (start_ev) begin
               clr_d   = 1'b1;
               lives_d = LivesInit;
               state_d = StPlay;
            end
         end
         StPlay: begin
            // A collision wins over a simultaneous pass.
            if (coll_ev) begin
               if (lives_q > 3'd1) begin
                  lives_d = lives_q - 3'd1;
                  hold_d  = HoldInit;
                  state_d = StHit;
               end else begin
                  lives_d      = 3'd0;
                  over_first_d = 1'b1;
                  state_d      = StOver;
               end
            end else if (pass_ev && !saturated) begin
               inc_d = 1'b1;
            end
         end
         StHit: begin
            if (pass_ev && !saturated) begin
               inc_d = 1'b1;
            end
            if (hold_q <= 16'd1) begin
               hold_d  = 16'd0;
               state_d = StPlay;
            end else begin
               hold_d = hold_q - 16'd1;
            end
         end
         StOver: begin
            // Digits are stable here: no increment is issued on the way into OVER.
            if (over_first_q && (score > hi_q)) begin
               hi_d       = score;
               new_high_d = 1'b1;
            end
            if (start_ev) begin
               clr_d      = 1'b1;
               lives_d    = LivesInit;
               new_high_d = 1'b0;
               state_d    = StPlay;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         lives_q      <= LivesInit;
         hi_q         <= 16'd0;
         hold_q       <= 16'd0;
         clr_q        <= 1'b0;
         inc_q        <= 1'b0;
         new_high_q   <= 1'b0;
         over_first_q <= 1'b0;
         // Prev set high so a level held through reset is not an event.
         start_prev_q <= 1'b1;
         pass_prev_q  <= 1'b1;
         coll_prev_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         lives_q      <= lives_d;
         hi_q         <= hi_d;
         hold_q       <= hold_d;
         clr_q        <= clr_d;
         inc_q        <= inc_d;
         new_high_q   <= new_high_d;
         over_first_q <= over_first_d;
         start_prev_q <= start;
         pass_prev_q  <= pass_evt;
         coll_prev_q  <= collision;
      end
   end

   assign score_clr  = clr_q;
   assign score_inc  = inc_q;
   assign lives      = lives_q;
   assign playing    = (state_q == StPlay) || (state_q == StHit);
   assign hit_active = (state_q == StHit);
   assign game_over  = (state_q == StOver);
   assign new_high   = new_high_q;
   assign hi_score   = hi_q;

endmodule
